imem_bank_arbiter: RTL and testbench
====================================

IMEM_BANK_ARBITER -- requirements
Module: imem_bank_arbiter

Interface
REQ-001 The block SHALL have parameters: NUM_REQ, default 3, number of CPU fetch requesters (>=2).
REQ-002 The block SHALL have parameters: NUM_BANKS, default 4, instruction banks (power of two, >=2).
REQ-003 The block SHALL have parameters: ADDR_W, default 32, byte address width; DATA_W, default 32, instruction width; CNT_W, default 16, stall counter width.
REQ-004 Derived: BANK_W = log2(NUM_BANKS); LINE_W = ADDR_W-2-BANK_W.
REQ-005 Port: clk  in  1  single clock, all state on rising edge.
REQ-006 Port: rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-007 Port: req_valid  in  NUM_REQ  fetch request per CPU.
REQ-008 Port: req_addr  in  NUM_REQ x ADDR_W  fetch byte address (PC) per CPU.
REQ-009 Port: req_ready  out  NUM_REQ  request granted this cycle.
REQ-010 Port: rsp_valid  out  NUM_REQ  instruction returned this cycle.
REQ-011 Port: rsp_data  out  NUM_REQ x DATA_W  returned instruction.
REQ-012 Port: bank_en  out  NUM_BANKS  bank read enable.
REQ-013 Port: bank_addr  out  NUM_BANKS x LINE_W  bank-local word index.
REQ-014 Port: bank_rdata  in  NUM_BANKS x DATA_W  bank read data, valid one cycle after bank_en.
REQ-015 Port: clr_cnt  in  1  synchronous clear of stall counters.
REQ-016 Port: stall_cnt  out  NUM_REQ x CNT_W  per-CPU stall cycle count.

Function
REQ-017 Bank select SHALL be req_addr[BANK_W+1:2]; line index req_addr[ADDR_W-1:BANK_W+2]; bits [1:0] ignored.
REQ-018 Each bank SHALL independently pick one winner among valid requesters targeting it, round-robin starting at its pointer ptr[b].
REQ-019 req_ready[i] SHALL be combinational, asserted in the same cycle as req_valid[i] when i wins its bank; requester holds valid/addr stable until ready.
REQ-020 bank_en[b] = any valid requester targets b; bank_addr[b] = winner's line index; bank_addr = 0 when bank_en = 0.
REQ-021 On a grant, ptr[b] SHALL update at the next edge to (winner+1) mod NUM_REQ; no grant -> ptr unchanged.
REQ-022 Response latency SHALL be exactly 1 cycle: rsp_valid[i] registered from req_ready[i]; rsp_data[i] = bank_rdata[registered bank of i].
REQ-023 rsp_data[i] SHALL be 0 whenever rsp_valid[i] = 0.
REQ-024 Requesters on distinct banks SHALL all be granted in the same cycle; k requesters on one bank serialize over k cycles with no bubble.
REQ-025 A requester granted in consecutive cycles SHALL get back-to-back rsp_valid.
REQ-026 stall_cnt[i] SHALL increment when req_valid[i] & !req_ready[i], saturating at 2^CNT_W-1; clr_cnt wins over increment in the same cycle.

Reset
REQ-027 On rst = 0: all ptr = 0, rsp_valid = 0, rsp_data = 0, stall_cnt = 0, registered bank selects = 0; req_ready/bank_en follow the combinational rules in REQ-019 and REQ-020.
REQ-028 Reset asserted mid-transfer SHALL drop any in-flight response; no rsp_valid in the first cycle after deassertion.

Structure
REQ-029 Package imem_bank_pkg SHALL hold the default NUM_REQ/NUM_BANKS/ADDR_W/DATA_W/CNT_W values, the BANK_W/LINE_W derivation, and the requester-id typedef.
REQ-030 One sub-module imem_bank_rr (per-bank round-robin picker plus ptr register) SHALL be instantiated NUM_BANKS times; response routing and counters stay in the top.

Verification
REQ-031 Reset, then CPU0/1/2 request addr 0x00/0x04/0x08 (banks 0/1/2) -> all req_ready=1 in cycle 0; rsp_valid=111 in cycle 1 with each bank's data.
REQ-032 All three request addr 0x10 (bank 0, line 1) from reset -> grants CPU0, CPU1, CPU2 on consecutive cycles; bank_addr[0]=1; stall_cnt ends at 0,1,2.
REQ-033 Hold CPU0 and CPU2 continuously on bank 3 -> grants alternate 0,2,0,2; CPU1 idle never shifts order.
REQ-034 Assert rst=0 in the cycle after a grant -> rsp_valid stays 0; ptr and stall_cnt return to 0.
REQ-035 Force CPU1 to stall 2^16+5 cycles (CNT_W=16) -> stall_cnt[1] saturates at 0xFFFF; clr_cnt with a stall active that cycle -> 0 next cycle.
REQ-036 Addresses 0x05 and 0x07 -> treated as word 0x04 (bank 1, line 0); both CPUs served over two consecutive cycles.

Source files
------------

// File: rtl/imem_bank_pkg.sv
// Shared sizing defaults and derived widths for the instruction-memory bank arbiter.
// Bank select and line index widths are both derived from the bank count.
package imem_bank_pkg;
    localparam int NUM_REQ_DEF   = 3;
    localparam int NUM_BANKS_DEF = 4;
    localparam int ADDR_W_DEF    = 32;
    localparam int DATA_W_DEF    = 32;
    localparam int CNT_W_DEF     = 16;

    function automatic int calc_bank_w(input int num_banks);
        return $clog2(num_banks);
    endfunction

    // Word-aligned addresses: two byte-offset bits sit below the bank select.
    function automatic int calc_line_w(input int addr_w, input int num_banks);
        return addr_w - 2 - $clog2(num_banks);
    endfunction

    localparam int REQ_ID_W = $clog2(NUM_REQ_DEF);
    typedef logic [REQ_ID_W-1:0] req_id_t;
endpackage

// File: rtl/imem_bank_rr.sv
// Round-robin picker for one instruction bank, holding its own rotating priority pointer.
// The pointer advances only on a grant, to the entry just after the winner.
module imem_bank_rr
    import imem_bank_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_hit,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] winner
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_idx;
    logic            w_found;

    always_comb begin
        grant   = '0;
        winner  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req_hit[w_idx]) begin
                w_found       = 1'b1;
                grant[w_idx]  = 1'b1;
                winner        = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
        end
    end
endmodule

// File: rtl/imem_bank_arbiter.sv
// Multi-CPU instruction fetch arbiter over word-interleaved banks with 1-cycle responses
// and per-CPU saturating stall counters.
module imem_bank_arbiter
    import imem_bank_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int NUM_BANKS = NUM_BANKS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    localparam int BANK_W   = calc_bank_w(NUM_BANKS),
    localparam int LINE_W   = calc_line_w(ADDR_W, NUM_BANKS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]       req_addr,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [NUM_REQ-1:0][DATA_W-1:0]       rsp_data,
    output logic [NUM_BANKS-1:0]                 bank_en,
    output logic [NUM_BANKS-1:0][LINE_W-1:0]     bank_addr,
    input  logic [NUM_BANKS-1:0][DATA_W-1:0]     bank_rdata,
    input  logic                                 clr_cnt,
    output logic [NUM_REQ-1:0][CNT_W-1:0]        stall_cnt
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0][BANK_W-1:0]      w_bank;
    logic [NUM_REQ-1:0][LINE_W-1:0]      w_line;
    logic [NUM_REQ-1:0][1:0]             w_unused_lsbs;
    logic [NUM_BANKS-1:0][NUM_REQ-1:0]   w_hit;
    logic [NUM_BANKS-1:0][NUM_REQ-1:0]   w_grant;
    logic [NUM_BANKS-1:0][ID_W-1:0]      w_win;
    logic [NUM_REQ-1:0]                  w_ready;
    logic [NUM_REQ-1:0]                  r_rsp_valid;
    logic [NUM_REQ-1:0][BANK_W-1:0]      r_rsp_bank;
    logic [NUM_REQ-1:0][CNT_W-1:0]       r_stall_cnt;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_decode
            assign w_bank[gi]        = req_addr[gi][BANK_W+1:2];
            assign w_line[gi]        = req_addr[gi][ADDR_W-1:BANK_W+2];
            assign w_unused_lsbs[gi] = req_addr[gi][1:0];
            assign rsp_data[gi]      = r_rsp_valid[gi] ? bank_rdata[r_rsp_bank[gi]] : '0;
        end

        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            for (gj = 0; gj < NUM_REQ; gj++) begin : g_hit
                assign w_hit[gi][gj] = req_valid[gj] && (w_bank[gj] == BANK_W'(gi));
            end

            imem_bank_rr #(
                .NUM_REQ (NUM_REQ)
            ) u_rr (
                .clk     (clk),
                .rst     (rst),
                .req_hit (w_hit[gi]),
                .grant   (w_grant[gi]),
                .winner  (w_win[gi])
            );

            assign bank_en[gi]   = |w_hit[gi];
            assign bank_addr[gi] = bank_en[gi] ? w_line[w_win[gi]] : '0;
        end
    endgenerate

    // Each requester targets exactly one bank, so OR-ing per-bank grants is exclusive.
    always_comb begin
        w_ready = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_ready = w_ready | w_grant[b];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= '0;
            r_rsp_bank  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_rsp_valid <= w_ready;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_ready[i]) begin
                    r_rsp_bank[i] <= w_bank[i];
                end
                if (clr_cnt) begin
                    r_stall_cnt[i] <= '0;
                end else if (req_valid[i] && !w_ready[i] && (r_stall_cnt[i] != '1)) begin
                    r_stall_cnt[i] <= r_stall_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = r_rsp_valid;
    assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_imem_bank_arbiter.sv
// Directed bench for imem_bank_arbiter: expected responses are queued per CPU at grant
// time and consumed by an independent monitor.
module tb_imem_bank_arbiter;
    import imem_bank_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [2:0]         req_valid;
    logic [2:0][31:0]   req_addr;
    logic [2:0]         req_ready;
    logic [2:0]         rsp_valid;
    logic [2:0][31:0]   rsp_data;
    logic [3:0]         bank_en;
    logic [3:0][27:0]   bank_addr;
    logic [3:0][31:0]   bank_rdata;
    logic               clr_cnt;
    logic [2:0][15:0]   stall_cnt;

    typedef struct packed {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[3][$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    imem_bank_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .bank_en    (bank_en),
        .bank_addr  (bank_addr),
        .bank_rdata (bank_rdata),
        .clr_cnt    (clr_cnt),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_bl(input logic [1:0] b, input logic [27:0] line);
        return {8'hB0, 2'b00, b, line[19:0]};
    endfunction

    // Bank memories: registered read, content encodes bank and line.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int b = 0; b < 4; b++) begin
            bank_rdata[b] <= bank_en[b] ? mk_bl(2'(b), bank_addr[b]) : 32'h0;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid[i] === 1'b1) begin
                if (exp_q[i].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rsp cpu%0d: got data %h expected no response (cycle %0d)",
                             i, rsp_data[i], cyc);
                end else begin
                    exp_t e;
                    e = exp_q[i].pop_front();
                    $display("rsp cpu%0d cycle %0d data %h", i, cyc, rsp_data[i]);
                    chk("rsp_data", 128'(rsp_data[i]), 128'(e.data));
                    chk("rsp_latency", 128'(cyc), 128'(e.cyc));
                end
            end else begin
                chk("rsp_data_idle", 128'(rsp_data[i]), 128'h0);
            end
        end
    end

    task automatic step(input logic [2:0] v, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [2:0] exp_rdy, input bit push = 1'b1);
        logic [31:0] a[3];
        @(negedge clk);
        a[0] = a0; a[1] = a1; a[2] = a2;
        req_valid = v;
        for (int i = 0; i < 3; i++) req_addr[i] = a[i];
        #1;
        chk("req_ready", 128'(req_ready), 128'(exp_rdy));
        if (push) begin
            for (int i = 0; i < 3; i++) begin
                if (exp_rdy[i]) exp_q[i].push_back('{cyc: cyc + 1, data: mk_bl(a[i][3:2], a[i][31:4])});
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req_valid = '0; clr_cnt = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_rsp_valid", 128'(rsp_valid), 128'h0);
        chk("reset_stall_cnt", 128'(stall_cnt), 128'h0);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; req_valid = '0; req_addr = '0; clr_cnt = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("init_rsp_valid", 128'(rsp_valid), 128'h0);
        chk("init_stall_cnt", 128'(stall_cnt), 128'h0);
        chk("init_bank_en", 128'(bank_en), 128'h0);
        chk("init_req_ready", 128'(req_ready), 128'h0);
        rst = 1'b1;

        // Distinct banks all granted together, twice back-to-back.
        step(3'b111, 32'h00, 32'h04, 32'h08, 3'b111);
        chk("s1_bank_en", 128'(bank_en), 128'h7);
        chk("s1_bank_addr", 128'(bank_addr), 128'h0);
        step(3'b111, 32'h14, 32'h18, 32'h1C, 3'b111);
        chk("s1b_bank_en", 128'(bank_en), 128'hE);
        chk("s1b_bank_addr3", 128'(bank_addr[3]), 128'h1);
        chk("s1b_bank_addr0", 128'(bank_addr[0]), 128'h0);
        step(3'b000, 32'h0, 32'h0, 32'h0, 3'b000);

        // Three CPUs on bank 0 line 1 serialize in order 0,1,2.
        do_reset();
        step(3'b111, 32'h10, 32'h10, 32'h10, 3'b001);
        chk("s2_bank_addr0", 128'(bank_addr[0]), 128'h1);
        chk("s2_bank_en", 128'(bank_en), 128'h1);
        step(3'b110, 32'h10, 32'h10, 32'h10, 3'b010);
        step(3'b100, 32'h10, 32'h10, 32'h10, 3'b100);
        step(3'b000, 32'h0, 32'h0, 32'h0, 3'b000);
        chk("s2_stall0", 128'(stall_cnt[0]), 128'd0);
        chk("s2_stall1", 128'(stall_cnt[1]), 128'd1);
        chk("s2_stall2", 128'(stall_cnt[2]), 128'd2);

        // CPU0 and CPU2 hammer bank 3; CPU1 idle does not disturb alternation.
        do_reset();
        step(3'b101, 32'h0C, 32'h0, 32'h1C, 3'b001);
        step(3'b101, 32'h0C, 32'h0, 32'h1C, 3'b100);
        step(3'b101, 32'h0C, 32'h0, 32'h1C, 3'b001);
        step(3'b101, 32'h0C, 32'h0, 32'h1C, 3'b100);
        step(3'b000, 32'h0, 32'h0, 32'h0, 3'b000);

        // Reset right after a grant drops the response and clears pointer and counters.
        do_reset();
        step(3'b011, 32'h00, 32'h00, 32'h0, 3'b001, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0; req_valid = '0;
        @(negedge clk);
        #1;
        chk("s4_rsp_valid", 128'(rsp_valid), 128'h0);
        chk("s4_stall1", 128'(stall_cnt[1]), 128'h0);
        rst = 1'b1;
        step(3'b011, 32'h00, 32'h00, 32'h0, 3'b001);
        step(3'b010, 32'h00, 32'h00, 32'h0, 3'b010);
        step(3'b000, 32'h0, 32'h0, 32'h0, 3'b000);

        // Unaligned addresses 0x05/0x07 map to bank 1 line 0.
        do_reset();
        step(3'b011, 32'h05, 32'h07, 32'h0, 3'b001);
        chk("s5_bank_en", 128'(bank_en), 128'h2);
        chk("s5_bank_addr1", 128'(bank_addr[1]), 128'h0);
        step(3'b010, 32'h05, 32'h07, 32'h0, 3'b010);
        step(3'b000, 32'h0, 32'h0, 32'h0, 3'b000);

        // Long forced stall on CPU1: counter saturates, then clear wins over increment.
        do_reset();
        @(negedge clk);
        force dut.w_ready = 3'b000;
        req_valid = 3'b010; req_addr[1] = 32'h04;
        repeat (65534) @(negedge clk);
        #1;
        chk("s6_stall_fffe", 128'(stall_cnt[1]), 128'hFFFE);
        repeat (7) @(negedge clk);
        #1;
        chk("s6_stall_sat", 128'(stall_cnt[1]), 128'hFFFF);
        clr_cnt = 1'b1;
        @(negedge clk);
        #1;
        chk("s6_stall_clr", 128'(stall_cnt[1]), 128'h0);
        clr_cnt = 1'b0;
        @(negedge clk);
        #1;
        chk("s6_stall_after_clr", 128'(stall_cnt[1]), 128'h1);
        req_valid = '0;
        release dut.w_ready;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("queue_empty", 128'(exp_q[i].size()), 128'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
